// File: rtl/png_unfilter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | png_unfilter : byte-serial PNG scanline reconstructor (filter types 0..4)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module png_unfilter #(
  parameter int SIZE = 4096,
  parameter int W_WD = 12,
  parameter int H_WD = 12,
  parameter int BPP  = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [W_WD-1:0] cfg_w_i,
  input  logic [H_WD-1:0] cfg_h_i,
  input  logic            start_i,
  input  logic            in_val_i,
  input  logic [7:0]      in_dat_i,
  output logic            in_rdy_o,
  output logic            out_val_o,
  output logic [7:0]      out_dat_o,
  output logic            out_lst_o,
  input  logic            out_ack_i,
  output logic            done_o,
  output logic            err_o
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TYPE  = 2'd1,
    S_DATA  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W_WD-1:0] r_col;
  logic [H_WD-1:0] r_row;
  logic [7:0]      r_ftype;
  logic [7:0]      r_a_sr [BPP];
  logic [7:0]      r_c_sr [BPP];
  logic [7:0]      r_linebuf [SIZE];
  logic            r_out_val;
  logic [7:0]      r_out_dat;
  logic            r_out_lst;
  logic            r_done;
  logic            r_err;

  logic            w_data_rdy;
  logic            w_data_fire;
  logic            w_last_col;
  logic            w_last_row;
  logic [AW-1:0]   w_idx;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [7:0]      w_c;
  logic [8:0]      w_avg_sum;
  logic signed [9:0] w_p, w_da, w_db, w_dc, w_pa, w_pb, w_pc;
  logic [7:0]      w_paeth;
  logic [7:0]      w_pred;
  logic [7:0]      w_recon;

  assign w_data_rdy  = !r_out_val || out_ack_i;
  assign w_data_fire = (r_state == S_DATA) && in_val_i && w_data_rdy;
  assign w_last_col  = (r_col == cfg_w_i - W_WD'(1));
  assign w_last_row  = (r_row == cfg_h_i - H_WD'(1));
  assign w_idx       = r_col[AW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_rdy_o    = 1'b0;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_TYPE;
      S_TYPE: begin
        in_rdy_o = 1'b1;
        if (in_val_i) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        in_rdy_o = w_data_rdy;
        if (in_val_i && w_data_rdy && w_last_col)
          w_state_nxt = w_last_row ? S_FLUSH : S_TYPE;
      end
      S_FLUSH: if (r_out_val && out_ack_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row 0 has no "up" row; c comes from delayed b so it is zero there too.
  assign w_a = r_a_sr[BPP-1];
  assign w_b = (r_row == '0) ? 8'h00 : r_linebuf[w_idx];
  assign w_c = r_c_sr[BPP-1];

  assign w_avg_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_p  = $signed({2'b00, w_a}) + $signed({2'b00, w_b}) - $signed({2'b00, w_c});
  assign w_da = w_p - $signed({2'b00, w_a});
  assign w_db = w_p - $signed({2'b00, w_b});
  assign w_dc = w_p - $signed({2'b00, w_c});
  assign w_pa = (w_da < 0) ? -w_da : w_da;
  assign w_pb = (w_db < 0) ? -w_db : w_db;
  assign w_pc = (w_dc < 0) ? -w_dc : w_dc;
  assign w_paeth = ((w_pa <= w_pb) && (w_pa <= w_pc)) ? w_a :
                   (w_pb <= w_pc) ? w_b : w_c;

  always_comb begin
    w_pred = 8'h00;
    case (r_ftype)
      8'd1:    w_pred = w_a;
      8'd2:    w_pred = w_b;
      8'd3:    w_pred = w_avg_sum[8:1];
      8'd4:    w_pred = w_paeth;
      default: w_pred = 8'h00;
    endcase
  end

  assign w_recon = in_dat_i + w_pred;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col     <= '0;
      r_row     <= '0;
      r_ftype   <= 8'h00;
      r_out_val <= 1'b0;
      r_out_dat <= 8'h00;
      r_out_lst <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < BPP; i++) begin
        r_a_sr[i] <= 8'h00;
        r_c_sr[i] <= 8'h00;
      end
    end else begin
      r_done <= (r_state == S_FLUSH) && r_out_val && out_ack_i;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_row <= '0;
          r_col <= '0;
          r_err <= 1'b0;
        end
        S_TYPE: begin
          for (int i = 0; i < BPP; i++) begin
            r_a_sr[i] <= 8'h00;
            r_c_sr[i] <= 8'h00;
          end
          if (in_val_i) begin
            r_ftype <= in_dat_i;
            r_col   <= '0;
            if (in_dat_i > 8'd4) r_err <= 1'b1;
          end
        end
        S_DATA: if (w_data_fire) begin
          r_a_sr[0] <= w_recon;
          r_c_sr[0] <= w_b;
          for (int i = 1; i < BPP; i++) begin
            r_a_sr[i] <= r_a_sr[i-1];
            r_c_sr[i] <= r_c_sr[i-1];
          end
          if (w_last_col) begin
            r_col <= '0;
            if (!w_last_row) r_row <= r_row + H_WD'(1);
          end else begin
            r_col <= r_col + W_WD'(1);
          end
        end
        default: ;
      endcase
      if (w_data_fire) begin
        r_out_val <= 1'b1;
        r_out_dat <= w_recon;
        r_out_lst <= w_last_col;
      end else if (out_ack_i) begin
        r_out_val <= 1'b0;
        r_out_lst <= 1'b0;
      end
    end
  end

  // The line buffer is write-after-read: b for this column was taken above.
  always_ff @(posedge clk) begin
    if (w_data_fire) r_linebuf[w_idx] <= w_recon;
  end

  assign out_val_o = r_out_val;
  assign out_dat_o = r_out_dat;
  assign out_lst_o = r_out_lst;
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule
`default_nettype wire
